// File: rtl/imem_loader.sv
// imem_loader: receives a program as a little-endian byte stream and writes it
// into instruction memory as 32-bit words at consecutive word addresses,
// holding the CPU in reset for the whole load session.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  err_overflow
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] len;
    logic [1:0]          byte_cnt;
    logic [ADDR_WIDTH:0] words_next;

    // Word count after the write currently on the bus retires.
    assign words_next = words_written + 1'b1;

    // Load-session FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            byte_cnt      <= '0;
            byte_ready    <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            err_overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        words_written <= '0;
                        err_overflow  <= 1'b0;
                        if (load_len > MAX_LEN) begin
                            // Would run past the end of memory: refuse the whole session.
                            err_overflow <= 1'b1;
                        end else if (load_len == '0) begin
                            state    <= DONE;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            len        <= load_len;
                            imem_addr  <= '0;
                            byte_cnt   <= '0;
                            cpu_hold   <= 1'b1;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid && byte_ready) begin
                        // First byte of a word lands in the LSB.
                        imem_wdata[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Address and data were stable for the single write cycle; advance now.
                    imem_we       <= 1'b0;
                    words_written <= words_next;
                    imem_addr     <= imem_addr + 1'b1;
                    byte_cnt      <= '0;
                    if (words_next == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cpu_hold   <= 1'b0;
                    byte_ready <= 1'b0;
                    imem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset, basic and stalled loads,
// boundary lengths, reset mid-load and start collisions while busy.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int MW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;
    logic          err_overflow;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            done_cnt = 0;
    int            viol_cnt = 0;

    imem_loader #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .words_written(words_written), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Record writes, done pulses and write/ready overlap away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (byte_ready === 1'b1) viol_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        viol_cnt = 0;
    endtask

    // Present n bytes from v (byte 0 in v[7:0]) honouring the handshake.
    task automatic send_bytes(input logic [63:0] v, input int n, input bit stall, output bit ok);
        int i = 0;
        int c = 0;
        logic rdy;
        logic vld;
        while (i < n && c < 200) begin
            vld = !(stall && ($urandom_range(0, 2) == 0));
            byte_valid = vld;
            byte_data  = vld ? v[8*i +: 8] : 8'($urandom);
            rdy = byte_ready;
            step();
            if (vld && rdy) i++;
            c++;
        end
        byte_valid = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int c = 0;
        while (done !== 1'b1 && c < limit) begin
            step();
            c++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_start = 1'($urandom);
            load_len   = 9'($urandom);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            step();
        end
        total++;
        if ({byte_ready, imem_we, cpu_hold, busy, done, err_overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {byte_ready, imem_we, cpu_hold, busy, done, err_overflow});
        end
        total++;
        if (imem_addr !== '0 || imem_wdata !== '0 || words_written !== '0) begin
            bad++;
            $display("FAIL reset_regs addr=%h wdata=%h ww=%0d want 0", imem_addr, imem_wdata, words_written);
        end
        reset = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        clear_log();
        step();
        step();
        total++;
        if (wr_addr.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle writes=%0d busy=%b want 0/0", wr_addr.size(), busy);
        end
    endtask

    task automatic run_two_words(input string tag, input bit stall);
        bit ok;
        clear_log();
        load_len = 9'd2; load_start = 1'b1;
        step();
        load_start = 1'b0;
        total++;
        if (cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_start hold=%b busy=%b rdy=%b want 111", tag, cpu_hold, busy, byte_ready);
        end
        send_bytes(64'hDEADBEEF_12345678, 8, stall, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_bytes_timeout accepted fewer than 8", tag); end
        wait_done(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_done_timeout done=%b want 1", tag, done); end
        total++;
        if (cpu_hold !== 1'b1 || words_written !== 9'd2) begin
            bad++;
            $display("FAIL %s_done_cycle hold=%b ww=%0d want 1/2", tag, cpu_hold, words_written);
        end
        step();
        total++;
        if (done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_after_done done=%b hold=%b busy=%b want 000", tag, done, cpu_hold, busy);
        end
        step(); step(); step();
        total++;
        if (words_written !== 9'd2 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s_hold_count ww=%0d done_pulses=%0d want 2/1", tag, words_written, done_cnt);
        end
        total++;
        if (wr_addr.size() != 2) begin
            bad++;
            $display("FAIL %s_write_count got=%0d want 2", tag, wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h12345678 ||
                     wr_addr[1] !== 8'd1 || wr_data[1] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL %s_write_vals got %h:%h %h:%h want 00:12345678 01:deadbeef",
                     tag, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        total++;
        if (viol_cnt != 0) begin
            bad++;
            $display("FAIL %s_we_with_ready got=%0d want 0", tag, viol_cnt);
        end
    endtask

    task automatic test_basic();
        run_two_words("basic", 1'b0);
    endtask

    task automatic test_stalled();
        run_two_words("stall", 1'b1);
    endtask

    task automatic test_boundary();
        clear_log();
        load_len = 9'd0; load_start = 1'b1;
        step();
        load_start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL len0_done done=%b busy=%b hold=%b want 111", done, busy, cpu_hold);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || words_written !== 9'd0 || wr_addr.size() != 0) begin
            bad++;
            $display("FAIL len0_after done=%b busy=%b ww=%0d writes=%0d want 0/0/0/0",
                     done, busy, words_written, wr_addr.size());
        end
        load_len = 9'(MW + 1); load_start = 1'b1;
        step();
        load_start = 1'b0;
        total++;
        if (err_overflow !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_flag err=%b busy=%b want 1/0", err_overflow, busy);
        end
        step(); step(); step();
        total++;
        if (err_overflow !== 1'b1 || busy !== 1'b0 || wr_addr.size() != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL ovf_sticky err=%b busy=%b writes=%0d pulses=%0d want 1/0/0/1",
                     err_overflow, busy, wr_addr.size(), done_cnt);
        end
        load_len = 9'(MW); load_start = 1'b1;
        step();
        load_start = 1'b0;
        total++;
        if (err_overflow !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ovf_clear err=%b busy=%b want 0/1", err_overflow, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_log();
        load_len = 9'd2; load_start = 1'b1;
        step();
        load_start = 1'b0;
        send_bytes(64'h0000BEEF_CAFEF00D, 6, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_bytes_timeout accepted fewer than 6"); end
        reset = 1'b1;
        byte_valid = 1'b1; byte_data = 8'hAA;
        step();
        reset = 1'b0;
        total++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0 || imem_we !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle hold=%b rdy=%b busy=%b we=%b want 0000",
                     cpu_hold, byte_ready, busy, imem_we);
        end
        for (int k = 0; k < 6; k++) step();
        byte_valid = 1'b0;
        total++;
        if (wr_addr.size() != 1) begin
            bad++;
            $display("FAIL midrst_writes got=%0d want 1", wr_addr.size());
        end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL midrst_word got %h:%h want 00:cafef00d", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_busy_collision();
        bit ok;
        clear_log();
        load_len = 9'd1; load_start = 1'b1;
        step();
        load_len = 9'd5;
        step();
        load_start = 1'b0;
        load_len = 9'd3;
        send_bytes(64'h00000000_A1B2C3D4, 4, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL coll_bytes_timeout accepted fewer than 4"); end
        wait_done(20, ok);
        total++;
        if (!ok || words_written !== 9'd1) begin
            bad++;
            $display("FAIL coll_done ok=%0d ww=%0d want 1/1", ok, words_written);
        end
        for (int k = 0; k < 8; k++) step();
        total++;
        if (busy !== 1'b0 || done_cnt != 1 || wr_addr.size() != 1 || words_written !== 9'd1) begin
            bad++;
            $display("FAIL coll_single busy=%b pulses=%0d writes=%0d ww=%0d want 0/1/1/1",
                     busy, done_cnt, wr_addr.size(), words_written);
        end else if (wr_data[0] !== 32'hA1B2C3D4) begin
            bad++;
            $display("FAIL coll_word got=%h want a1b2c3d4", wr_data[0]);
        end
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        test_reset();
        test_basic();
        test_stalled();
        test_boundary();
        test_reset_mid_load();
        test_busy_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the PC/instruction-memory fetch path: receives a program as a byte stream and writes it into instruction memory as 32-bit words at word addresses 0, 1, 2, ...
- Assembles bytes little-endian, issues one memory write per completed word, and holds the CPU (`cpu_hold`) for the whole load.
- Sits between the host/boot byte source and the instruction-memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MEM_WORDS, 256, instruction-memory capacity in words; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load session; honoured only in IDLE.
- load_len  in  ADDR_WIDTH+1  number of words to load; sampled when load_start is accepted.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  word being written.
- cpu_hold  out  1  keeps the PC/CPU in reset while loading.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a session completes.
- words_written  out  ADDR_WIDTH+1  words written in the current/last session.
- err_overflow  out  1  sticky; set when a request has load_len > MEM_WORDS.

Behaviour:
- All outputs are registered.
- Reset (sync, active-high): state=IDLE; byte_ready, imem_we, cpu_hold, busy, done, err_overflow = 0; imem_addr, imem_wdata, words_written = 0; byte counter = 0.
- Reset asserted mid-session:
  - The partial word is discarded and no further write is issued.
  - Words already written stay in memory.
  - Next cycle is IDLE with cpu_hold=0.
- Byte handshake: a byte transfers on a cycle where byte_valid && byte_ready. byte_data must be held while byte_valid=1 && byte_ready=0.
- States:
  - IDLE:
    - byte_ready=0, cpu_hold=0.
    - On load_start, clear err_overflow and words_written, then:
      - load_len > MEM_WORDS: set err_overflow=1, stay in IDLE, no writes.
      - load_len == 0: go to DONE.
      - Otherwise: latch len, imem_addr=0, byte counter=0, cpu_hold=1, go to COLLECT.
  - COLLECT:
    - byte_ready=1.
    - Each accepted byte k (k=0..3) goes into imem_wdata[8k+7:8k]; the first byte is the LSB.
    - When byte 3 is accepted, go to WRITE.
  - WRITE:
    - imem_we=1 for exactly one cycle, with imem_addr and imem_wdata stable; byte_ready=0.
    - On exit: words_written+1, imem_addr+1, byte counter=0.
    - If the new words_written == len, go to DONE; otherwise go to COLLECT.
  - DONE:
    - done=1 for exactly one cycle; cpu_hold stays 1 during this cycle.
    - Then IDLE, where cpu_hold=0 and busy=0.
- Latency and throughput:
  - If byte 3 is accepted at edge N, imem_we is high in the cycle following edge N.
  - Minimum 5 cycles per word (4 byte cycles + 1 write cycle).
- busy = (state != IDLE). cpu_hold = busy.
- load_start is ignored when not in IDLE; load_len changes outside the accept cycle have no effect.
- imem_addr never exceeds MEM_WORDS-1 during a write; no wrap-around is possible because of the overflow check.
- Bytes offered outside COLLECT are not accepted (byte_ready=0).
- words_written holds its final value after DONE until the next accepted load_start or reset.

Test Plan:
1. Reset: assert reset 2 cycles with random inputs → every output 0; state IDLE; no imem_we.
2. Basic load:
   - Stimulus: load_len=2, bytes 78,56,34,12,EF,BE,AD,DE with byte_valid held high.
   - Required: exactly two writes, addr0=0x12345678 then addr1=0xDEADBEEF, each one cycle.
   - Required: done pulses once; words_written=2; cpu_hold high from the cycle after load_start through the done cycle, then low.
3. Stalled source: same 8 bytes with byte_valid deasserted on random cycles → identical writes and values; no extra imem_we; imem_we never high in a cycle with byte_ready=1.
4. Boundary lengths:
   - load_len=0 → done pulse with no imem_we; words_written=0.
   - load_len=MEM_WORDS+1 → err_overflow=1, busy stays 0, no writes.
   - A following valid load_start clears err_overflow.
5. Reset mid-load: load_len=2, send 6 bytes, assert reset → only addr0 written; no write to addr1; next cycle IDLE, cpu_hold=0, byte_ready=0.
6. Busy collision: assert load_start with load_len=5 during a 1-word load → ignored; first session ends with words_written=1 and a single done pulse.
